// File: rtl/core_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// core_bus_arbiter_if
//   Bundles the core-side request/response pulses and the downstream bus
//   pulses handled by core_bus_arbiter.
//
//   Core side (per channel i):
//     req_enable[i], req_mode[i]  one-cycle request pulse, 1 = write
//     req_addr/req_wdata/req_wstrb  channel i at [i*AW +: AW] / [i*DW +: DW] /
//                                   [i*DW/8 +: DW/8]
//     resp_enable[i], resp_data   one-cycle response pulse and its data
//     busy[i]                     channel i holds a pending or in-flight request
//   Downstream side:
//     bus_request_enable, breq_*  one-cycle request pulse and held fields
//     bus_response_enable, bresp_data  one-cycle response pulse and data
//
//   Modports:
//     slave   the arbiter's view
//     master  the environment's view (requesters plus downstream bus)
// ---------------------------------------------------------------------------
interface core_bus_arbiter_if #(
  parameter int NCH = 2,
  parameter int AW  = 32,
  parameter int DW  = 32
);
  localparam int SW = DW / 8;

  // Core side
  logic [NCH-1:0]    req_enable;
  logic [NCH-1:0]    req_mode;
  logic [NCH*AW-1:0] req_addr;
  logic [NCH*DW-1:0] req_wdata;
  logic [NCH*SW-1:0] req_wstrb;
  logic [NCH-1:0]    resp_enable;
  logic [DW-1:0]     resp_data;
  logic [NCH-1:0]    busy;

  // Downstream side
  logic              bus_request_enable;
  logic              breq_mode;
  logic [AW-1:0]     breq_addr;
  logic [DW-1:0]     breq_wdata;
  logic [SW-1:0]     breq_wstrb;
  logic              bus_response_enable;
  logic [DW-1:0]     bresp_data;

  modport slave (
    input  req_enable, req_mode, req_addr, req_wdata, req_wstrb,
    output resp_enable, resp_data, busy,
    output bus_request_enable, breq_mode, breq_addr, breq_wdata, breq_wstrb,
    input  bus_response_enable, bresp_data
  );

  modport master (
    output req_enable, req_mode, req_addr, req_wdata, req_wstrb,
    input  resp_enable, resp_data, busy,
    input  bus_request_enable, breq_mode, breq_addr, breq_wdata, breq_wstrb,
    output bus_response_enable, bresp_data
  );
endinterface

// File: rtl/core_bus_arbiter.sv
// ---------------------------------------------------------------------------
// core_bus_arbiter
//   Merges NCH core-side bus masters (fetch, mem, page walker, debug, ...)
//   onto one downstream bus using the core's one-cycle pulse protocol.
//   Each channel holds one outstanding request; one downstream transaction
//   is in flight at a time.
//
//   Ports:
//     clk   clock
//     rstn  asynchronous active-low reset
//     bus   core_bus_arbiter_if.slave (see interface header for signals)
//
//   Timing:
//     req_enable at t into an idle arbiter  -> bus_request_enable at t+1
//     bus_response_enable at r              -> resp_enable at r+1, busy clear
//     next bus_request_enable               -> r+2 at the earliest
//
//   Build option:
//     CORE_BUS_ARB_FIXED_PRIO_EN  defined: fixed priority, lowest index wins.
//                                 undefined (default): round-robin.
// ---------------------------------------------------------------------------
module core_bus_arbiter #(
  parameter int NCH = 2,
  parameter int AW  = 32,
  parameter int DW  = 32
) (
  input  logic              clk,
  input  logic              rstn,
  core_bus_arbiter_if.slave bus
);
  localparam int SW = DW / 8;
  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e          state_q, state_d;
  logic [NCH-1:0]  busy_q, busy_d;
  logic [PW-1:0]   owner_q;           // channel of the in-flight transaction

  logic [NCH-1:0]  slot_mode_q;
  logic [AW-1:0]   slot_addr_q  [NCH];
  logic [DW-1:0]   slot_wdata_q [NCH];
  logic [SW-1:0]   slot_wstrb_q [NCH];

  logic            breq_en_q;
  logic            breq_mode_q;
  logic [AW-1:0]   breq_addr_q;
  logic [DW-1:0]   breq_wdata_q;
  logic [SW-1:0]   breq_wstrb_q;

  logic [NCH-1:0]  resp_en_q, resp_en_d;
  logic [DW-1:0]   resp_data_q;

`ifndef CORE_BUS_ARB_FIXED_PRIO_EN
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
`endif

  // ---------------------------------------------------------------------------
  // Per-channel view of the flat request buses
  // ---------------------------------------------------------------------------
  logic [AW-1:0]   in_addr  [NCH];
  logic [DW-1:0]   in_wdata [NCH];
  logic [SW-1:0]   in_wstrb [NCH];

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      in_addr[i]  = bus.req_addr[i*AW +: AW];
      in_wdata[i] = bus.req_wdata[i*DW +: DW];
      in_wstrb[i] = bus.req_wstrb[i*SW +: SW];
    end
  end

  // ---------------------------------------------------------------------------
  // Acceptance and arbitration
  //   A request on a busy channel is a protocol violation and is dropped.
  //   Same-cycle accepted requests join the candidate set directly, so an idle
  //   arbiter launches one cycle after the request pulse.
  // ---------------------------------------------------------------------------
  logic [NCH-1:0]  accept;
  logic [NCH-1:0]  cand;
  logic            win_found;
  logic [PW-1:0]   winner;
  logic [PW-1:0]   probe;
`ifndef CORE_BUS_ARB_FIXED_PRIO_EN
  logic [PW:0]     probe_sum;
`endif

  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    accept    = bus.req_enable & ~busy_q;
    cand      = busy_q | accept;
    win_found = 1'b0;
    winner    = '0;
    probe     = '0;
`ifndef CORE_BUS_ARB_FIXED_PRIO_EN
    probe_sum = '0;
`endif
    for (int k = 0; k < NCH; k++) begin
`ifdef CORE_BUS_ARB_FIXED_PRIO_EN
      probe = PW'(k);
`else
      // Ascending search from the pointer, wrapping modulo NCH.
      probe_sum = {1'b0, rr_ptr_q} + (PW+1)'(k);
      if (probe_sum >= (PW+1)'(NCH)) begin
        probe_sum = probe_sum - (PW+1)'(NCH);
      end
      probe = probe_sum[PW-1:0];
`endif
      if (!win_found && cand[probe]) begin
        win_found = 1'b1;
        winner    = probe;
      end
    end
  end

  // Winner's fields: from its slot if it was already pending, otherwise
  // straight from this cycle's request inputs.
  logic            win_mode;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_wdata;
  logic [SW-1:0]   win_wstrb;

  always_comb begin
    if (busy_q[winner]) begin
      win_mode  = slot_mode_q[winner];
      win_addr  = slot_addr_q[winner];
      win_wdata = slot_wdata_q[winner];
      win_wstrb = slot_wstrb_q[winner];
    end else begin
      win_mode  = bus.req_mode[winner];
      win_addr  = in_addr[winner];
      win_wdata = in_wdata[winner];
      win_wstrb = in_wstrb[winner];
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state and transaction events
  // ---------------------------------------------------------------------------
  logic launch;
  logic complete;

  always_comb begin
    state_d  = state_q;
    launch   = 1'b0;
    complete = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // A response pulse here has no owner and is ignored.
        if (win_found) begin
          launch  = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.bus_response_enable) begin
          complete = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_d    = busy_q | accept;
    resp_en_d = '0;
    if (complete) begin
      // Busy drops in the same cycle the response pulse is presented, so the
      // channel may re-request while its resp_enable is high.
      busy_d[owner_q]    = 1'b0;
      resp_en_d[owner_q] = 1'b1;
    end
  end

`ifndef CORE_BUS_ARB_FIXED_PRIO_EN
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (launch) begin
      rr_ptr_d = (winner == PW'(NCH - 1)) ? '0 : winner + 1'b1;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      busy_q       <= '0;
      owner_q      <= '0;
      breq_en_q    <= 1'b0;
      breq_mode_q  <= 1'b0;
      breq_addr_q  <= '0;
      breq_wdata_q <= '0;
      breq_wstrb_q <= '0;
      resp_en_q    <= '0;
      resp_data_q  <= '0;
`ifndef CORE_BUS_ARB_FIXED_PRIO_EN
      rr_ptr_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      breq_en_q <= launch;
      resp_en_q <= resp_en_d;
`ifndef CORE_BUS_ARB_FIXED_PRIO_EN
      rr_ptr_q  <= rr_ptr_d;
`endif
      // Downstream fields change only on a launch and are held otherwise.
      if (launch) begin
        owner_q      <= winner;
        breq_mode_q  <= win_mode;
        breq_addr_q  <= win_addr;
        breq_wdata_q <= win_wdata;
        breq_wstrb_q <= win_wstrb;
      end
      // Response data is kept between responses.
      if (complete) begin
        resp_data_q <= bus.bresp_data;
      end
    end
  end

  // NOTE: the slot payload is not reset; it is only read while its busy bit
  // is set, and the busy bits are reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (accept[i]) begin
        slot_mode_q[i]  <= bus.req_mode[i];
        slot_addr_q[i]  <= in_addr[i];
        slot_wdata_q[i] <= in_wdata[i];
        slot_wstrb_q[i] <= in_wstrb[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.busy               = busy_q;
  assign bus.resp_enable        = resp_en_q;
  assign bus.resp_data          = resp_data_q;
  assign bus.bus_request_enable = breq_en_q;
  assign bus.breq_mode          = breq_mode_q;
  assign bus.breq_addr          = breq_addr_q;
  assign bus.breq_wdata         = breq_wdata_q;
  assign bus.breq_wstrb         = breq_wstrb_q;

`ifndef SYNTHESIS
  a_resp_onehot: assert property (@(posedge clk) disable iff (!rstn)
    $onehot0(resp_en_q));
  a_launch_waits: assert property (@(posedge clk) disable iff (!rstn)
    breq_en_q |-> (state_q == ST_WAIT));
`endif

endmodule
